fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage for the single-issue core. Holds the architectural PC register, issues one instruction-memory read per instruction over a valid/ready request channel, and presents the fetched word to decode with a valid/ready handshake. It sits directly upstream of the next-PC logic: its `pc` output feeds that logic, and the computed next PC (`pc_ifu`) returns here on `pc_next` with a `pc_load` strobe.

## Interface
- `XLEN`, 32: datapath and address width.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pc`  out  XLEN  current PC register; drives next-PC logic.
- `pc_next`  in  XLEN  next PC (`pc_ifu` from the next-PC logic).
- `pc_load`  in  1  strobe: load `pc_next` and fetch it.
- `imem_req_valid`  out  1  fetch request pending.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_addr`  out  XLEN  fetch address.
- `imem_rsp_valid`  in  1  read data returned; single-cycle pulse, no backpressure.
- `imem_rsp_data`  in  32  instruction word.
- `imem_rsp_err`  in  1  access fault on this response.
- `inst_valid`  out  1  instruction available to decode.
- `inst_ready`  in  1  decode consumes the instruction.
- `inst`  out  32  instruction word; 0 when `inst_fault`.
- `inst_pc`  out  XLEN  PC of `inst`.
- `inst_fault`  out  1  fetch faulted (access error or misalignment).

## Operation
- Four-state FSM:
  - FETCH: `imem_req_valid`=1 and `imem_addr`=`pc`. On `imem_req_ready`, go to WAIT.
  - WAIT: wait for the response. On `imem_rsp_valid`, capture data and err into `inst`/`inst_fault` and go to VALID. `inst` is 0 if `imem_rsp_err`.
  - VALID: `inst_valid`=1; `inst`, `inst_pc`, `inst_fault` are held stable. On `inst_ready`:
    - with `pc_load` in the same cycle, load `pc_next` and go to FETCH;
    - otherwise go to EXEC.
  - EXEC: instruction consumed, waiting for the next PC. On `pc_load`, load `pc_next` and go to FETCH.
- `pc_load` is ignored in FETCH, WAIT, and in VALID without `inst_ready`. `pc` is unchanged in those cases.
- `imem_rsp_valid` outside WAIT is dropped. This includes a stale response arriving after reset.
- `imem_rsp_valid` in the same cycle as a FETCH handshake is dropped. Memory must respond no earlier than the cycle after acceptance.
- `inst_pc` always equals `pc` while `inst_valid`=1.

## Timing
- Reset (async assert, deassert synchronous to `clk` by the system):
  - state=FETCH, `pc`=`RESET_PC`;
  - `imem_req_valid`=1, `inst_valid`=0, `inst`=0, `inst_fault`=0, `inst_pc`=`RESET_PC`.
- Reset asserted mid-operation aborts any outstanding request immediately. A pending `inst_valid` drops the same instant.
- All outputs are decoded from registers; there are no combinational input-to-output paths.
- Latency with a zero-wait memory (`imem_req_ready`=1, response the cycle after acceptance):
  - `pc_load` at cycle N: `imem_req_valid` at N+1, `inst_valid` at N+3;
  - back-to-back throughput is one instruction per 3 cycles.
- `imem_req_valid` stays high with a constant `imem_addr` until accepted.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined:
  - on entering FETCH with `pc[1:0]`≠0, no memory request is issued (`imem_req_valid`=0);
  - the FSM goes directly to VALID the next cycle with `inst_fault`=1 and `inst`=0.
- `FETCH_MISALIGN_CHECK_EN` undefined:
  - `imem_addr[1:0]` is forced to 2'b00 and the fetch proceeds normally;
  - `inst_pc` keeps the unaligned value;
  - no misalignment fault is raised.

## Test plan
- Reset, `imem_req_ready`=1, response 32'h0000_0013 one cycle after acceptance -> `imem_addr`=0 first, `inst_valid` at cycle 2, `inst`=32'h0000_0013, `inst_pc`=0.
- `inst_ready`=1 with `pc_load`=1 and `pc_next`=32'h0000_0004 in the same cycle -> next request `imem_addr`=4; `inst_valid` 3 cycles later.
- `imem_req_ready` low for 5 cycles -> `imem_req_valid` held with a constant address; a spurious `imem_rsp_valid` during this is dropped (no `inst_valid`).
- Response with `imem_rsp_err`=1 -> `inst_valid`=1, `inst_fault`=1, `inst`=0. `pc_load` while `inst_ready`=0 -> `pc` unchanged.
- `pc_next`=32'h0000_0102, `FETCH_MISALIGN_CHECK_EN` defined -> no request, `inst_fault`=1, `inst_pc`=32'h0000_0102. Undefined -> `imem_addr`=32'h0000_0100, `inst_fault`=0.
- `rst_n` asserted while in WAIT, response arrives after deassert -> response dropped, `imem_addr`=`RESET_PC`, `inst_valid` stays 0 until the new response.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, imem request/response sequencing and decode handshake.
// Optional FETCH_MISALIGN_CHECK_EN turns a misaligned PC into a fault instead of a word-aligned fetch.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] pc_next,
  input  logic            pc_load,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_fault
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2,
    S_EXEC  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic            fault_q, fault_d;
  logic            misalign;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign  = (pc_q[1:0] != 2'b00);
  assign imem_addr = pc_q;
`else
  // Low address bits are dropped; the unaligned PC itself is still reported on inst_pc.
  assign misalign  = 1'b0;
  assign imem_addr = {pc_q[XLEN-1:2], 2'b00};
`endif

  assign pc             = pc_q;
  assign inst_pc        = pc_q;
  assign inst           = inst_q;
  assign inst_fault     = fault_q;
  assign inst_valid     = (state_q == S_VALID);
  assign imem_req_valid = (state_q == S_FETCH) && !misalign;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    fault_d = fault_q;
    case (state_q)
      S_FETCH: begin
        if (misalign) begin
          state_d = S_VALID;
          inst_d  = 32'h0;
          fault_d = 1'b1;
        end else if (imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Responses seen in any other state are stale and ignored.
        if (imem_rsp_valid) begin
          state_d = S_VALID;
          inst_d  = imem_rsp_err ? 32'h0 : imem_rsp_data;
          fault_d = imem_rsp_err;
        end
      end
      S_VALID: begin
        if (inst_ready) begin
          if (pc_load) begin
            pc_d    = pc_next;
            state_d = S_FETCH;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        if (pc_load) begin
          pc_d    = pc_next;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed steps then randomized fetches against a word-addressed memory model.
module tb_fetch_unit;
  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc, pc_next = '0;
  logic        pc_load = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        imem_rsp_err = 1'b0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [31:0] inst, inst_pc;
  logic        inst_fault;

  fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .pc_next(pc_next), .pc_load(pc_load),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .inst_fault(inst_fault)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  logic [31:0] mem [0:255];
  logic [31:0] cur_pc;
  logic [31:0] exp_inst;
  logic        exp_fault;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in the first FETCH cycle of the instruction at epc; returns in its VALID cycle.
  task automatic do_fetch(input logic [31:0] epc, input int stall, input int rwait,
                          input logic err, input bit spurious);
    logic [31:0] a;
    a = {epc[31:2], 2'b00};
`ifdef FETCH_MISALIGN_CHECK_EN
    if (epc[1:0] != 2'b00) begin
      chk("misalign_no_req", imem_req_valid, 1'b0);
      step();
      exp_inst  = 32'h0;
      exp_fault = 1'b1;
      chk("misalign_valid", inst_valid, 1'b1);
      chk("misalign_fault", inst_fault, 1'b1);
      chk("misalign_inst", inst, 32'h0);
      chk("misalign_inst_pc", inst_pc, epc);
      return;
    end
`endif
    chk("req_valid", imem_req_valid, 1'b1);
    chk("req_addr", imem_addr, a);
    chk("no_inst_in_fetch", inst_valid, 1'b0);
    for (int i = 0; i < stall; i++) begin
      imem_req_ready = 1'b0;
      imem_rsp_valid = spurious;
      imem_rsp_data  = 32'hdead_beef;
      pc_load        = 1'($urandom_range(0, 1));
      pc_next        = $urandom;
      step();
      imem_rsp_valid = 1'b0;
      pc_load        = 1'b0;
      chk("stall_req_held", imem_req_valid, 1'b1);
      chk("stall_addr_const", imem_addr, a);
      chk("stall_no_inst", inst_valid, 1'b0);
      chk("stall_pc_kept", pc, epc);
    end
    // A response coincident with acceptance is stale and must not complete the fetch.
    imem_req_ready = 1'b1;
    imem_rsp_valid = spurious;
    imem_rsp_data  = 32'hdead_beef;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    chk("accepted_req_low", imem_req_valid, 1'b0);
    chk("wait_no_inst", inst_valid, 1'b0);
    for (int i = 0; i < rwait; i++) begin
      step();
      chk("rsp_wait_no_inst", inst_valid, 1'b0);
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = mem[a[9:2]];
    imem_rsp_err   = err;
    step();
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    imem_rsp_data  = $urandom;
    exp_inst  = err ? 32'h0 : mem[a[9:2]];
    exp_fault = err;
    chk("inst_valid", inst_valid, 1'b1);
    chk("inst_data", inst, exp_inst);
    chk("inst_pc", inst_pc, epc);
    chk("inst_fault", inst_fault, exp_fault);
    chk("valid_no_req", imem_req_valid, 1'b0);
  endtask

  // Called in a VALID cycle; returns in the FETCH cycle for nxt.
  task automatic consume(input int delay, input bit with_load, input int exec_wait,
                         input logic [31:0] nxt);
    for (int i = 0; i < delay; i++) begin
      inst_ready = 1'b0;
      pc_load    = 1'b1;
      pc_next    = $urandom;
      step();
      pc_load = 1'b0;
      chk("held_valid", inst_valid, 1'b1);
      chk("held_pc", pc, cur_pc);
      chk("held_inst", inst, exp_inst);
      chk("held_fault", inst_fault, exp_fault);
    end
    inst_ready = 1'b1;
    pc_load    = with_load;
    pc_next    = nxt;
    step();
    inst_ready = 1'b0;
    pc_load    = 1'b0;
    chk("consumed_valid_low", inst_valid, 1'b0);
    if (!with_load) begin
      for (int i = 0; i <= exec_wait; i++) begin
        chk("exec_no_req", imem_req_valid, 1'b0);
        chk("exec_pc_kept", pc, cur_pc);
        if (i < exec_wait) step();
      end
      pc_load = 1'b1;
      pc_next = nxt;
      step();
      pc_load = 1'b0;
    end
    cur_pc = nxt;
    chk("pc_loaded", pc, cur_pc);
  endtask

  task automatic release_reset();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h0000_0013;

    // Reset state
    #2;
    chk("rst_req_valid", imem_req_valid, 1'b1);
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_fault", inst_fault, 1'b0);
    chk("rst_inst_pc", inst_pc, RESET_PC);
    chk("rst_pc", pc, RESET_PC);
    step();
    release_reset();
    cur_pc = RESET_PC;

    // First fetch at zero-wait latency, then back-to-back load of 0x4
    do_fetch(cur_pc, 0, 0, 1'b0, 1'b0);
    chk("first_inst", inst, 32'h0000_0013);
    consume(0, 1'b1, 0, 32'h4);
    do_fetch(cur_pc, 0, 0, 1'b0, 1'b0);

    // Five-cycle stall with spurious responses
    consume(1, 1'b0, 2, 32'h40);
    do_fetch(cur_pc, 5, 1, 1'b0, 1'b1);

    // Access fault, pc_load ignored while decode stalls
    consume(0, 1'b1, 0, 32'h80);
    do_fetch(cur_pc, 0, 0, 1'b1, 1'b0);
    consume(3, 1'b1, 0, 32'h102);

    // Misaligned PC
    do_fetch(cur_pc, 0, 0, 1'b0, 1'b0);
`ifndef FETCH_MISALIGN_CHECK_EN
    chk("unaligned_fault_clear", inst_fault, 1'b0);
`endif
    consume(0, 1'b1, 0, 32'h200);

    // Reset while waiting for a response; stale response afterwards
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wait_req", imem_req_valid, 1'b1);
    chk("rst_wait_addr", imem_addr, RESET_PC);
    chk("rst_wait_inst_valid", inst_valid, 1'b0);
    release_reset();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hbad0_0bad;
    step();
    imem_rsp_valid = 1'b0;
    chk("stale_dropped", inst_valid, 1'b0);
    chk("stale_addr", imem_addr, RESET_PC);
    step();
    chk("stale_still_none", inst_valid, 1'b0);
    cur_pc = RESET_PC;
    do_fetch(cur_pc, 0, 0, 1'b0, 1'b0);

    // Reset while an instruction is pending drops inst_valid at once
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid_drop", inst_valid, 1'b0);
    chk("rst_valid_pc", pc, RESET_PC);
    release_reset();
    cur_pc = RESET_PC;

    // Randomized fetch/consume traffic
    for (int it = 0; it < 40; it++) begin
      logic [31:0] nxt;
      nxt = 32'($urandom_range(0, 255)) << 2;
      if ($urandom_range(0, 5) == 0) nxt = nxt | 32'($urandom_range(1, 3));
      do_fetch(cur_pc, $urandom_range(0, 3), $urandom_range(0, 2),
               1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
      consume($urandom_range(0, 2), 1'($urandom_range(0, 1)), $urandom_range(0, 2), nxt);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

endmodule
